mem_arbiter: RTL

//   Shares the single-ported main memory between the I-cache and D-cache miss handlers.
//   - I-side requests are block fills only.
//   - D-side requests are block fills or single-word writes (write-through).
//   - Sits between the fetch/memory stage miss FSMs and main memory.
//   - Requesters stall their pipeline stage until their done pulse.
//

---
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates the single-ported main memory between the I-cache and D-cache miss handlers.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration (default: D-side priority).
module mem_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int BLOCK_WORDS = 8,
  localparam int WI         = $clog2(BLOCK_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_grant,
  output logic              i_data_vld,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_grant,
  output logic              d_data_vld,
  output logic              d_done,
  output logic [DATA_W-1:0] rdata,
  output logic [WI-1:0]     word_idx,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvld,
  output logic [1:0]        dbgState
);

  // Handshake: a requester raises req and holds it (with stable inputs) until its done
  // pulse; it must drop req in the following cycle or it is granted again.
  typedef enum logic [1:0] {IDLE, FILL_I, FILL_D, WRITE_D} stateT;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BLOCK_WORDS * 2 - 1);
  localparam logic [WI:0]       NUM_WORDS  = (WI + 1)'(BLOCK_WORDS);
  localparam logic [WI-1:0]     LAST_IDX   = WI'(BLOCK_WORDS - 1);

  stateT             state;
  logic [WI:0]       issueCnt;
  logic [WI-1:0]     retCnt;
  logic [ADDR_W-1:0] baseAddr;
  logic [ADDR_W-1:0] iBase;
  logic [ADDR_W-1:0] dBase;
  logic              pickI;
  logic              pickD;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic rrPtrD;  // side that wins the next tie: 1 = D, 0 = I
`endif

  assign iBase = i_addr & ALIGN_MASK;
  assign dBase = d_addr & ALIGN_MASK;

  always_comb begin
    pickI = 1'b0;
    pickD = 1'b0;
    if (i_req && d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (rrPtrD) pickD = 1'b1;
      else        pickI = 1'b1;
`else
      pickD = 1'b1;
`endif
    end else if (d_req) begin
      pickD = 1'b1;
    end else if (i_req) begin
      pickI = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      issueCnt  <= '0;
      retCnt    <= '0;
      baseAddr  <= '0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rrPtrD    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          mem_en   <= 1'b0;
          mem_wr   <= 1'b0;
          issueCnt <= '0;
          retCnt   <= '0;
          if (pickD && d_we) begin
            state     <= WRITE_D;
            mem_en    <= 1'b1;
            mem_wr    <= 1'b1;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
          end else if (pickD) begin
            state    <= FILL_D;
            baseAddr <= dBase;
            mem_en   <= 1'b1;
            mem_addr <= dBase;
            issueCnt <= (WI + 1)'(1);
          end else if (pickI) begin
            state    <= FILL_I;
            baseAddr <= iBase;
            mem_en   <= 1'b1;
            mem_addr <= iBase;
            issueCnt <= (WI + 1)'(1);
          end
`ifdef MEM_ARB_ROUND_ROBIN_EN
          if (pickD)      rrPtrD <= 1'b0;
          else if (pickI) rrPtrD <= 1'b1;
`endif
        end
        FILL_I, FILL_D: begin
          // issueCnt counts commands already placed on the bus; word 0 went out on grant.
          if (issueCnt < NUM_WORDS) begin
            mem_en   <= 1'b1;
            mem_addr <= baseAddr + (ADDR_W'(issueCnt) << 1);
            issueCnt <= issueCnt + 1'b1;
          end else begin
            mem_en <= 1'b0;
          end
          if (mem_rvld) begin
            retCnt <= retCnt + 1'b1;
            if (retCnt == LAST_IDX) begin
              state  <= IDLE;
              retCnt <= '0;
            end
          end
        end
        WRITE_D: begin
          state  <= IDLE;
          mem_en <= 1'b0;
          mem_wr <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign i_grant    = (state == FILL_I);
  assign d_grant    = (state == FILL_D) || (state == WRITE_D);
  assign i_data_vld = (state == FILL_I) && mem_rvld;
  assign d_data_vld = (state == FILL_D) && mem_rvld;
  assign i_done     = i_data_vld && (retCnt == LAST_IDX);
  assign d_done     = (d_data_vld && (retCnt == LAST_IDX)) || (state == WRITE_D);
  assign rdata      = mem_rdata;
  assign word_idx   = retCnt;
  assign dbgState   = state;

endmodule
